// File: rtl/rx_block_assembler.sv
// ----------------------------------------------------------------------------
// rx_block_assembler
//
// Collects NBYTES bytes of BYTE_W bits from a valid/ready byte stream (UART
// receiver side) into one wide block and presents it on a valid/ready output
// (AES core side). The block is held until the consumer takes it. The
// assembler can also:
//   - place bytes in LSB-first or MSB-first slot order,
//   - emit a partial block on request (flush_i) or after TIMEOUT_CYC idle
//     cycles,
//   - record bytes that were dropped because the block was still being held
//     (sticky overrun_o).
// Everything is synchronous to clk_i. rst_rx is asynchronous and active-low.
//
// Parameters
//   BYTE_W      width of one input byte
//   NBYTES      bytes per block (>= 2)
//   MSB_FIRST   0: byte k -> slot k, 1: byte k -> slot NBYTES-1-k
//   TIMEOUT_CYC idle FILL cycles before a partial block is emitted (0 = off)
//
// Ports
//   clk_i         system clock, rising edge
//   rst_rx        asynchronous active-low reset
//   in_valid_i    in_byte_i is valid
//   in_ready_o    a byte is accepted this cycle when in_valid_i is high
//   in_byte_i     received byte
//   flush_i       request to emit the partial block being filled
//   blk_valid_o   blk_data_o / blk_count_o / blk_partial_o are valid
//   blk_ready_i   consumer takes the presented block
//   blk_data_o    assembled block, unfilled slots are zero
//   blk_count_o   bytes in the block (fill level while filling)
//   blk_partial_o block was emitted with fewer than NBYTES bytes
//   overrun_o     sticky: a byte arrived while in_ready_o was low
//   clr_err_i     synchronous clear of overrun_o (a new overrun wins)
// ----------------------------------------------------------------------------
module rx_block_assembler #(
    parameter int BYTE_W      = 8,
    parameter int NBYTES      = 16,
    parameter int MSB_FIRST   = 0,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_rx,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [BYTE_W-1:0]               in_byte_i,
    input  logic                            flush_i,
    output logic                            blk_valid_o,
    input  logic                            blk_ready_i,
    output logic [NBYTES*BYTE_W-1:0]        blk_data_o,
    output logic [$clog2(NBYTES+1)-1:0]     blk_count_o,
    output logic                            blk_partial_o,
    output logic                            overrun_o,
    input  logic                            clr_err_i
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = NBYTES * BYTE_W;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   data_q, data_d;
    logic [CW-1:0]   count_q, count_d;
    logic            partial_q, partial_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            overrun_q, overrun_d;
    logic            valid_q;

    logic            ready_s;
    logic            accept_s;
    logic            tmo_hit_s;
    logic [CW-1:0]   count_inc_s;
    logic [CW-1:0]   slot_s;
    logic [BW-1:0]   wr_data_s;

    // Ready is a pure decode of the state so the producer sees it without
    // waiting a cycle after the block is released.
    assign ready_s     = (state_q != ST_HOLD);
    assign accept_s    = in_valid_i & ready_s;
    assign count_inc_s = count_q + {{(CW-1){1'b0}}, 1'b1};

    // Slot for the next byte; count_q never reaches NBYTES outside HOLD, so
    // the MSB-first subtraction cannot underflow while a byte is accepted.
    assign slot_s = (MSB_FIRST != 0) ? (CW'(NBYTES - 1) - count_q) : count_q;

    // The timeout fires on the idle cycle that would bring the counter to
    // TIMEOUT_CYC, so the block is presented exactly TIMEOUT_CYC cycles
    // after the last accepted byte.
    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            assign tmo_hit_s = (tmo_q == TW'(TIMEOUT_CYC - 1));
        end else begin : g_no_tmo
            assign tmo_hit_s = 1'b0;
        end
    endgenerate

    // Current block with the incoming byte merged into its slot.
    always_comb begin
        wr_data_s = data_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (slot_s == CW'(k)) begin
                wr_data_s[k*BYTE_W +: BYTE_W] = in_byte_i;
            end else begin
                wr_data_s[k*BYTE_W +: BYTE_W] = data_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state logic for the fill/hold FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        partial_d = partial_q;
        tmo_d     = tmo_q;

        case (state_q)
            ST_IDLE: begin
                // Flush and timeout have nothing to emit here; NBYTES >= 2
                // means a single byte can never complete a block.
                if (accept_s) begin
                    data_d  = wr_data_s;
                    count_d = count_inc_s;
                    tmo_d   = {TW{1'b0}};
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (accept_s) begin
                    data_d  = wr_data_s;
                    count_d = count_inc_s;
                    tmo_d   = {TW{1'b0}};
                end else if (TIMEOUT_CYC > 0) begin
                    tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    tmo_d = tmo_q;
                end

                // A byte arriving with flush is stored first; if it completes
                // the block the block counts as full, not partial.
                if (accept_s && (count_inc_s == CW'(NBYTES))) begin
                    state_d   = ST_HOLD;
                    partial_d = 1'b0;
                    tmo_d     = {TW{1'b0}};
                end else if (flush_i || (!accept_s && tmo_hit_s)) begin
                    state_d   = ST_HOLD;
                    partial_d = 1'b1;
                    tmo_d     = {TW{1'b0}};
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_HOLD: begin
                if (blk_ready_i) begin
                    state_d   = ST_IDLE;
                    data_d    = {BW{1'b0}};
                    count_d   = {CW{1'b0}};
                    partial_d = 1'b0;
                    tmo_d     = {TW{1'b0}};
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                // Unreachable encoding: return to a clean empty state.
                state_d   = ST_IDLE;
                data_d    = {BW{1'b0}};
                count_d   = {CW{1'b0}};
                partial_d = 1'b0;
                tmo_d     = {TW{1'b0}};
            end
        endcase
    end

    // Sticky overrun flag; a drop in the same cycle as clr_err_i keeps it set.
    always_comb begin
        if (in_valid_i && !ready_s) begin
            overrun_d = 1'b1;
        end else if (clr_err_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State, datapath and flag registers.
    always_ff @(posedge clk_i or negedge rst_rx) begin
        if (!rst_rx) begin
            state_q   <= ST_IDLE;
            data_q    <= {BW{1'b0}};
            count_q   <= {CW{1'b0}};
            partial_q <= 1'b0;
            tmo_q     <= {TW{1'b0}};
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            count_q   <= count_d;
            partial_q <= partial_d;
            tmo_q     <= tmo_d;
            overrun_q <= overrun_d;
            valid_q   <= (state_d == ST_HOLD);
        end
    end

    assign in_ready_o    = ready_s;
    assign blk_valid_o   = valid_q;
    assign blk_data_o    = data_q;
    assign blk_count_o   = count_q;
    assign blk_partial_o = partial_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// ----------------------------------------------------------------------------
// Testbench for rx_block_assembler. Two instances share the same stimulus:
//   dut0: MSB_FIRST=0, TIMEOUT_CYC=10
//   dut1: MSB_FIRST=1, TIMEOUT_CYC=0
// Directed scenarios check fixed expected values; a randomized phase checks
// every output each cycle against a byte-list reference model.
// ----------------------------------------------------------------------------
module tb_rx_block_assembler;

    localparam int NB = 16;
    localparam int CW = $clog2(NB + 1);
    localparam int TO0 = 10;

    logic clk = 1'b0;
    logic rst_rx = 1'b0;
    logic iv = 1'b0;
    logic [7:0] ib = 8'h00;
    logic fl = 1'b0;
    logic br = 1'b0;
    logic ce = 1'b0;

    logic rdy [2];
    logic vld [2];
    logic part [2];
    logic ovr [2];
    logic [127:0] bdata [2];
    logic [CW-1:0] bcnt [2];

    int checks = 0;
    int failures = 0;

    // Reference model: list of received bytes per instance plus flags.
    int mcnt [2];
    logic [7:0] mbytes [2][NB];
    bit mhold [2];
    bit mpart [2];
    bit movr [2];
    int midle [2];
    int mto [2] = '{TO0, 0};
    bit mmsb [2] = '{1'b0, 1'b1};

    rx_block_assembler #(.BYTE_W(8), .NBYTES(NB), .MSB_FIRST(0), .TIMEOUT_CYC(TO0)) dut0 (
        .clk_i(clk), .rst_rx(rst_rx), .in_valid_i(iv), .in_ready_o(rdy[0]),
        .in_byte_i(ib), .flush_i(fl), .blk_valid_o(vld[0]), .blk_ready_i(br),
        .blk_data_o(bdata[0]), .blk_count_o(bcnt[0]), .blk_partial_o(part[0]),
        .overrun_o(ovr[0]), .clr_err_i(ce)
    );

    rx_block_assembler #(.BYTE_W(8), .NBYTES(NB), .MSB_FIRST(1), .TIMEOUT_CYC(0)) dut1 (
        .clk_i(clk), .rst_rx(rst_rx), .in_valid_i(iv), .in_ready_o(rdy[1]),
        .in_byte_i(ib), .flush_i(fl), .blk_valid_o(vld[1]), .blk_ready_i(br),
        .blk_data_o(bdata[1]), .blk_count_o(bcnt[1]), .blk_partial_o(part[1]),
        .overrun_o(ovr[1]), .clr_err_i(ce)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mhold[d] = 1'b0; mpart[d] = 1'b0; movr[d] = 1'b0; midle[d] = 0;
        end
    endtask

    // Apply the inputs present at this clock edge to the model.
    task automatic model_update();
        bit acc;
        bit was_fill;
        if (!rst_rx) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                acc = iv && !mhold[d];
                if (iv && mhold[d]) movr[d] = 1'b1;
                else if (ce) movr[d] = 1'b0;
                if (mhold[d]) begin
                    if (br) begin
                        mhold[d] = 1'b0; mcnt[d] = 0; mpart[d] = 1'b0; midle[d] = 0;
                    end
                end else begin
                    was_fill = (mcnt[d] > 0);
                    if (acc) begin
                        mbytes[d][mcnt[d]] = ib;
                        mcnt[d] = mcnt[d] + 1;
                        midle[d] = 0;
                    end else if (was_fill) begin
                        midle[d] = midle[d] + 1;
                    end
                    if (mcnt[d] == NB) begin
                        mhold[d] = 1'b1; mpart[d] = 1'b0; midle[d] = 0;
                    end else if (was_fill && (fl || (mto[d] > 0 && midle[d] == mto[d]))) begin
                        mhold[d] = 1'b1; mpart[d] = 1'b1; midle[d] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [127:0] exp_data(input int d);
        logic [127:0] r;
        int s;
        r = '0;
        for (int k = 0; k < mcnt[d]; k++) begin
            s = mmsb[d] ? (NB - 1 - k) : k;
            r[s*8 +: 8] = mbytes[d][k];
        end
        return r;
    endfunction

    // One clock: edge, model update, then settle before sampling.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        iv = 1'b1; ib = b;
        step();
        iv = 1'b0;
    endtask

    task automatic test_reset();
        rst_rx = 1'b0; iv = 1'b0; fl = 1'b0; br = 1'b0; ce = 1'b0;
        step(); step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b0 || bdata[d] !== 128'h0 || bcnt[d] !== 5'd0 ||
                part[d] !== 1'b0 || ovr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: valid=%b data=%h count=%0d partial=%b overrun=%b, required all zero",
                         d, vld[d], bdata[d], bcnt[d], part[d], ovr[d]);
            end
        end
        rst_rx = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready dut%0d: in_ready=%b, required 1", d, rdy[d]);
            end
        end
    endtask

    task automatic test_full_block();
        br = 1'b1;
        for (int i = 0; i < NB; i++) begin
            send_byte(8'(i));
            if (i == NB - 2) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (vld[d] !== 1'b0 || bcnt[d] !== 5'd15) begin
                        failures++;
                        $display("FAIL full_early dut%0d: valid=%b count=%0d, required 0/15", d, vld[d], bcnt[d]);
                    end
                end
            end
        end
        checks++;
        if (bdata[0] !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            failures++;
            $display("FAIL full_lsb_data: got %h, required 0f0e0d0c0b0a09080706050403020100", bdata[0]);
        end
        checks++;
        if (bdata[1] !== 128'h000102030405060708090A0B0C0D0E0F) begin
            failures++;
            $display("FAIL full_msb_data: got %h, required 000102030405060708090a0b0c0d0e0f", bdata[1]);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b1 || bcnt[d] !== 5'd16 || part[d] !== 1'b0 || rdy[d] !== 1'b0) begin
                failures++;
                $display("FAIL full_flags dut%0d: valid=%b count=%0d partial=%b ready=%b, required 1/16/0/0",
                         d, vld[d], bcnt[d], part[d], rdy[d]);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b0 || bcnt[d] !== 5'd0 || bdata[d] !== 128'h0 || rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL full_release dut%0d: valid=%b count=%0d data=%h ready=%b, required 0/0/0/1",
                         d, vld[d], bcnt[d], bdata[d], rdy[d]);
            end
        end
        br = 1'b0;
    endtask

    task automatic test_flush();
        logic [127:0] hold0;
        br = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
        fl = 1'b1;
        step();
        fl = 1'b0;
        checks++;
        if (bdata[0] !== {88'h0, 40'hA5A4A3A2A1}) begin
            failures++;
            $display("FAIL flush_lsb_data: got %h, required upper zero, low a5a4a3a2a1", bdata[0]);
        end
        checks++;
        if (bdata[1] !== {40'hA1A2A3A4A5, 88'h0}) begin
            failures++;
            $display("FAIL flush_msb_data: got %h, required a1a2a3a4a5 then zeros", bdata[1]);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b1 || bcnt[d] !== 5'd5 || part[d] !== 1'b1) begin
                failures++;
                $display("FAIL flush_flags dut%0d: valid=%b count=%0d partial=%b, required 1/5/1",
                         d, vld[d], bcnt[d], part[d]);
            end
        end
        hold0 = bdata[0];
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (vld[0] !== 1'b1 || bdata[0] !== hold0 || bcnt[0] !== 5'd5) begin
            failures++;
            $display("FAIL flush_hold: valid=%b data=%h count=%0d, required held block", vld[0], bdata[0], bcnt[0]);
        end
        br = 1'b1;
        step();
        br = 1'b0;
        checks++;
        if (vld[0] !== 1'b0 || vld[1] !== 1'b0 || part[0] !== 1'b0) begin
            failures++;
            $display("FAIL flush_release: valid=%b/%b partial=%b, required 0/0/0", vld[0], vld[1], part[0]);
        end
    endtask

    task automatic test_timeout();
        int lat;
        br = 1'b0;
        lat = -1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        for (int k = 1; k <= 30; k++) begin
            step();
            if (vld[0] === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != TO0) begin
            failures++;
            $display("FAIL timeout_latency: blk_valid after %0d cycles (-1 = never), required %0d", lat, TO0);
        end
        checks++;
        if (bcnt[0] !== 5'd3 || part[0] !== 1'b1 || bdata[0] !== {104'h0, 24'h332211}) begin
            failures++;
            $display("FAIL timeout_block: count=%0d partial=%b data=%h, required 3/1/...332211", bcnt[0], part[0], bdata[0]);
        end
        checks++;
        if (vld[1] !== 1'b0 || bcnt[1] !== 5'd3) begin
            failures++;
            $display("FAIL timeout_disabled: valid=%b count=%0d, required 0/3", vld[1], bcnt[1]);
        end
        fl = 1'b1;
        step();
        fl = 1'b0;
        checks++;
        if (vld[1] !== 1'b1 || part[1] !== 1'b1 || bdata[1] !== {24'h112233, 104'h0}) begin
            failures++;
            $display("FAIL timeout_flush_msb: valid=%b partial=%b data=%h, required 1/1/112233...", vld[1], part[1], bdata[1]);
        end
        br = 1'b1;
        step();
        br = 1'b0;
    endtask

    task automatic test_hold_overrun();
        logic [127:0] e0;
        logic [127:0] e1;
        br = 1'b0;
        e0 = '0; e1 = '0;
        for (int i = 0; i < NB; i++) begin
            e0[i*8 +: 8] = 8'h40 + 8'(i);
            e1[(NB-1-i)*8 +: 8] = 8'h40 + 8'(i);
            send_byte(8'h40 + 8'(i));
        end
        for (int c = 0; c < 20; c++) begin
            iv = 1'b1; ib = 8'($urandom);
            step();
            checks++;
            if (bdata[0] !== e0 || bdata[1] !== e1 || rdy[0] !== 1'b0 || ovr[0] !== 1'b1 ||
                ovr[1] !== 1'b1 || vld[0] !== 1'b1 || bcnt[1] !== 5'd16) begin
                failures++;
                $display("FAIL hold_stable c%0d: data0=%h data1=%h ready=%b overrun=%b/%b valid=%b count=%0d",
                         c, bdata[0], bdata[1], rdy[0], ovr[0], ovr[1], vld[0], bcnt[1]);
            end
        end
        ce = 1'b1;
        step();
        checks++;
        if (ovr[0] !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set_wins: overrun=%b, required 1", ovr[0]);
        end
        iv = 1'b0;
        step();
        ce = 1'b0;
        checks++;
        if (ovr[0] !== 1'b0 || ovr[1] !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b/%b, required 0/0", ovr[0], ovr[1]);
        end
        br = 1'b1;
        step();
        br = 1'b0;
        checks++;
        if (vld[0] !== 1'b0 || bdata[0] !== 128'h0 || bcnt[0] !== 5'd0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: valid=%b data=%h count=%0d ready=%b, required 0/0/0/1",
                     vld[0], bdata[0], bcnt[0], rdy[0]);
        end
        send_byte(8'h99);
        checks++;
        if (bcnt[0] !== 5'd1 || bdata[0] !== {120'h0, 8'h99} || ovr[0] !== 1'b0) begin
            failures++;
            $display("FAIL hold_next_byte: count=%0d data=%h overrun=%b, required 1/...99/0", bcnt[0], bdata[0], ovr[0]);
        end
        fl = 1'b1; step(); fl = 1'b0;
        br = 1'b1; step(); br = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] e0;
        for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
        rst_rx = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b0 || bdata[d] !== 128'h0 || bcnt[d] !== 5'd0 || part[d] !== 1'b0 || ovr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid dut%0d: valid=%b data=%h count=%0d partial=%b overrun=%b, required zero",
                         d, vld[d], bdata[d], bcnt[d], part[d], ovr[d]);
            end
        end
        step();
        rst_rx = 1'b1;
        step();
        br = 1'b0;
        e0 = '0;
        for (int i = 0; i < NB; i++) begin
            e0[i*8 +: 8] = 8'h50 + 8'(i);
            send_byte(8'h50 + 8'(i));
        end
        checks++;
        if (vld[0] !== 1'b1 || bdata[0] !== e0 || bcnt[0] !== 5'd16 || part[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_new_block: valid=%b data=%h count=%0d partial=%b, required 1/%h/16/0",
                     vld[0], bdata[0], bcnt[0], part[0], e0);
        end
        br = 1'b1; step(); br = 1'b0;
    endtask

    task automatic test_random();
        int pv;
        rst_rx = 1'b0; iv = 1'b0; fl = 1'b0; br = 1'b0; ce = 1'b0;
        step();
        rst_rx = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            pv = ((c / 500) % 2 == 0) ? 65 : 12;
            iv = ($urandom_range(0, 99) < pv);
            ib = 8'($urandom);
            br = ($urandom_range(0, 99) < 35);
            ce = ($urandom_range(0, 99) < 6);
            fl = ($urandom_range(0, 99) < 4);
            // Keep flush away from a byte landing on an empty assembler.
            if (iv && ((!mhold[0] && mcnt[0] == 0) || (!mhold[1] && mcnt[1] == 0))) fl = 1'b0;
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (vld[d] !== mhold[d] || rdy[d] !== !mhold[d] || bcnt[d] !== CW'(mcnt[d]) ||
                    part[d] !== mpart[d] || ovr[d] !== movr[d] || bdata[d] !== exp_data(d)) begin
                    failures++;
                    $display("FAIL random c%0d dut%0d: v=%b r=%b n=%0d p=%b o=%b d=%h, required v=%b r=%b n=%0d p=%b o=%b d=%h",
                             c, d, vld[d], rdy[d], bcnt[d], part[d], ovr[d], bdata[d],
                             mhold[d], !mhold[d], mcnt[d], mpart[d], movr[d], exp_data(d));
                end
            end
        end
        iv = 1'b0; fl = 1'b0; br = 1'b0; ce = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_block();
        test_flush();
        test_timeout();
        test_hold_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
